// File: rtl/yin_cmnd_search_pkg.sv
// Shared types, default geometry and the cmnd saturation helper for the YIN back end.
package yin_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int TAUMAX_DEF     = 2048;
    localparam int LANES_DEF      = 4;
    localparam int FRAC_DEF       = 10;
    localparam int DIV_STAGES_DEF = 8;

    localparam int ACC_W  = 2 * WIDTH_DEF + $clog2(TAUMAX_DEF);
    localparam int CMND_W = FRAC_DEF + 4;
    // Widest quotient the saturator accepts; narrower geometries zero-extend into it.
    localparam int QUO_W  = ACC_W + FRAC_DEF;

    typedef logic [CMND_W-1:0] cmnd_t;

    typedef enum logic [2:0] {IDLE, SUM, DIV, UPD, DONE} state_t;

    function automatic cmnd_t sat_cmnd(input logic [QUO_W-1:0] q);
        cmnd_t r;
        if (q > QUO_W'({CMND_W{1'b1}})) begin
            r = '1;
        end else begin
            r = q[CMND_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/yin_cmnd_search_fp_div.sv
// Fixed-point divider: (dividend << FRACTION_WIDTH) / divisor, truncated, NUM_STAGES cycles latency.
// A zero divisor returns quotient 0 with err set.
module fp_div #(
    parameter int WIDTH          = 32,
    parameter int FRACTION_WIDTH = 10,
    parameter int NUM_STAGES     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH-1:0]                dividend_in,
    input  logic [WIDTH-1:0]                divisor_in,
    output logic [WIDTH+FRACTION_WIDTH-1:0] quotient_out,
    output logic                            err_out
);

    localparam int QW = WIDTH + FRACTION_WIDTH;

    logic [QW-1:0] quo_d;
    logic          err_d;
    logic [QW-1:0] quo_q [NUM_STAGES];
    logic          err_q [NUM_STAGES];

    // The divide is one combinational step ahead of a delay line; retiming distributes it.
    always_comb begin
        err_d = (divisor_in == '0);
        quo_d = '0;
        if (!err_d) begin
            quo_d = {dividend_in, {FRACTION_WIDTH{1'b0}}} / {{FRACTION_WIDTH{1'b0}}, divisor_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                quo_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            quo_q[0] <= quo_d;
            err_q[0] <= err_d;
            for (int i = 1; i < NUM_STAGES; i++) begin
                quo_q[i] <= quo_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    assign quotient_out = quo_q[NUM_STAGES-1];
    assign err_out      = err_q[NUM_STAGES-1];

endmodule

// File: rtl/yin_cmnd_search.sv
// YIN back end: cumulative-mean-normalised difference and absolute-threshold dip search
// over one frame of d(tau), LANES taus per beat, result returned on a ready/valid port.
module yin_cmnd_search
    import yin_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int TAUMAX     = TAUMAX_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int FRAC       = FRAC_DEF,
    parameter int DIV_STAGES = DIV_STAGES_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [LANES*2*WIDTH-1:0]  diff_in,
    input  logic                      diff_valid_in,
    input  logic                      diff_last_in,
    output logic                      diff_ready_out,
    input  logic [FRAC-1:0]           threshold_in,
    input  logic [$clog2(TAUMAX)-1:0] tau_lo_in,
    output logic                      result_valid_out,
    input  logic                      result_ready_in,
    output logic [$clog2(TAUMAX)-1:0] tau_out,
    output logic [FRAC+3:0]           cmnd_out,
    output logic                      voiced_out
);

    localparam int TAU_W = $clog2(TAUMAX);
    localparam int DW    = 2 * WIDTH;
    localparam int AW    = DW + TAU_W;
    localparam int QW    = AW + FRAC;
    localparam int CNT_W = $clog2(DIV_STAGES + 1);
    localparam logic [TAU_W-1:0] LAST_BASE = TAU_W'(TAUMAX - LANES);

    typedef logic [TAU_W-1:0] tau_t;

    state_t              state_q, state_d;
    tau_t                base_q, base_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [LANES*DW-1:0] beat_q, beat_d;
    logic                last_q, last_d;
    logic [FRAC-1:0]     thr_q, thr_d;
    tau_t                tau_lo_q, tau_lo_d;
    logic [AW-1:0]       num_q [LANES];
    logic [AW-1:0]       num_d [LANES];
    logic [AW-1:0]       den_q [LANES];
    logic [AW-1:0]       den_d [LANES];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    cmnd_t               best_cmnd_q, best_cmnd_d;
    tau_t                best_tau_q, best_tau_d;
    logic                dip_q, dip_d;
    logic                locked_q, locked_d;
    logic                res_valid_q, res_valid_d;
    tau_t                res_tau_q, res_tau_d;
    cmnd_t               res_cmnd_q, res_cmnd_d;
    logic                res_voiced_q, res_voiced_d;

    tau_t          lane_tau [LANES];
    logic [QW-1:0] quo      [LANES];
    logic          div_err  [LANES];

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_tau[j] = base_q + tau_t'(j);
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_div
        fp_div #(
            .WIDTH          (AW),
            .FRACTION_WIDTH (FRAC),
            .NUM_STAGES     (DIV_STAGES)
        ) u_div (
            .clk          (clk_in),
            .rst_n        (rst_n_in),
            .dividend_in  (num_q[j]),
            .divisor_in   (den_q[j]),
            .quotient_out (quo[j]),
            .err_out      (div_err[j])
        );
    end

    assign diff_ready_out = (state_q == IDLE) && (!res_valid_q || result_ready_in);

    always_comb begin : next_state
        logic [AW-1:0] run;
        logic [DW-1:0] d_lane;
        cmnd_t         c;
        tau_t          tau_min;

        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d      = state_q;
        base_d       = base_q;
        acc_d        = acc_q;
        beat_d       = beat_q;
        last_d       = last_q;
        thr_d        = thr_q;
        tau_lo_d     = tau_lo_q;
        num_d        = num_q;
        den_d        = den_q;
        cnt_d        = cnt_q;
        best_cmnd_d  = best_cmnd_q;
        best_tau_d   = best_tau_q;
        dip_d        = dip_q;
        locked_d     = locked_q;
        res_valid_d  = res_valid_q && !result_ready_in;
        res_tau_d    = res_tau_q;
        res_cmnd_d   = res_cmnd_q;
        res_voiced_d = res_voiced_q;
        run          = acc_q;
        d_lane       = '0;
        c            = '0;
        tau_min      = (tau_lo_q == '0) ? tau_t'(1) : tau_lo_q;

        unique case (state_q)
            IDLE: begin
                if (diff_valid_in && diff_ready_out) begin
                    beat_d  = diff_in;
                    last_d  = diff_last_in || (base_q == LAST_BASE);
                    if (base_q == '0) begin
                        thr_d    = threshold_in;
                        tau_lo_d = tau_lo_in;
                    end
                    state_d = SUM;
                end
            end
            SUM: begin
                // d(0) is excluded from the running mean denominator.
                for (int j = 0; j < LANES; j++) begin
                    d_lane = beat_q[j*DW +: DW];
                    if (lane_tau[j] != '0) begin
                        run = run + AW'(d_lane);
                    end
                    den_d[j] = run;
                    num_d[j] = AW'(lane_tau[j]) * AW'(d_lane);
                end
                acc_d   = run;
                cnt_d   = '0;
                state_d = DIV;
            end
            DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_STAGES - 1)) begin
                    state_d = UPD;
                end
            end
            UPD: begin
                for (int j = 0; j < LANES; j++) begin
                    c = sat_cmnd(QUO_W'(quo[j]));
                    if (!locked_d && !div_err[j] && lane_tau[j] >= tau_min) begin
                        if (!dip_d) begin
                            if (c < cmnd_t'(thr_q)) begin
                                dip_d       = 1'b1;
                                best_cmnd_d = c;
                                best_tau_d  = lane_tau[j];
                            end else if (c < best_cmnd_d) begin
                                best_cmnd_d = c;
                                best_tau_d  = lane_tau[j];
                            end
                        end else if (c <= best_cmnd_d) begin
                            best_cmnd_d = c;
                            best_tau_d  = lane_tau[j];
                        end else begin
                            locked_d = 1'b1;
                        end
                    end
                end
                if (last_q) begin
                    base_d  = '0;
                    acc_d   = '0;
                    state_d = DONE;
                end else begin
                    base_d  = base_q + tau_t'(LANES);
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (!res_valid_q || result_ready_in) begin
                    res_valid_d  = 1'b1;
                    res_tau_d    = best_tau_q;
                    res_cmnd_d   = best_cmnd_q;
                    res_voiced_d = dip_q;
                    best_cmnd_d  = '1;
                    best_tau_d   = '0;
                    dip_d        = 1'b0;
                    locked_d     = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= only; blocking here would race against readers of the old value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            base_q       <= '0;
            acc_q        <= '0;
            beat_q       <= '0;
            last_q       <= 1'b0;
            thr_q        <= '0;
            tau_lo_q     <= '0;
            // NOTE: the divider operand arrays are reset too, so no X ever reaches the divide.
            for (int j = 0; j < LANES; j++) begin
                num_q[j] <= '0;
                den_q[j] <= '0;
            end
            cnt_q        <= '0;
            best_cmnd_q  <= '1;
            best_tau_q   <= '0;
            dip_q        <= 1'b0;
            locked_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            res_tau_q    <= '0;
            res_cmnd_q   <= '0;
            res_voiced_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            acc_q        <= acc_d;
            beat_q       <= beat_d;
            last_q       <= last_d;
            thr_q        <= thr_d;
            tau_lo_q     <= tau_lo_d;
            num_q        <= num_d;
            den_q        <= den_d;
            cnt_q        <= cnt_d;
            best_cmnd_q  <= best_cmnd_d;
            best_tau_q   <= best_tau_d;
            dip_q        <= dip_d;
            locked_q     <= locked_d;
            res_valid_q  <= res_valid_d;
            res_tau_q    <= res_tau_d;
            res_cmnd_q   <= res_cmnd_d;
            res_voiced_q <= res_voiced_d;
        end
    end

    assign result_valid_out = res_valid_q;
    assign tau_out          = res_tau_q;
    assign cmnd_out         = res_cmnd_q;
    assign voiced_out       = res_voiced_q;

endmodule

// File: tb/tb_yin_cmnd_search.sv
// Scoreboard bench for yin_cmnd_search: directed YIN frames plus randomized frames checked
// against an arithmetic reference model, with a decoupled result monitor.
module tb_yin_cmnd_search;

    localparam int WIDTH      = 16;
    localparam int TAUMAX     = 16;
    localparam int LANES      = 4;
    localparam int FRAC       = 10;
    localparam int DIV_STAGES = 8;
    localparam int P          = DIV_STAGES + 3;
    localparam int TAU_W      = $clog2(TAUMAX);
    localparam int DW         = 2 * WIDTH;
    localparam longint CMND_MAX = (64'd1 << (FRAC + 4)) - 1;

    typedef struct {
        int tau;
        int cmnd;
        int voiced;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [LANES*DW-1:0]   diff_in = '0;
    logic                  diff_valid = 1'b0;
    logic                  diff_last = 1'b0;
    logic                  diff_ready;
    logic [FRAC-1:0]       threshold = '0;
    logic [TAU_W-1:0]      tau_lo = '0;
    logic                  result_valid;
    logic                  result_ready = 1'b1;
    logic [TAU_W-1:0]      tau_o;
    logic [FRAC+3:0]       cmnd_o;
    logic                  voiced_o;

    exp_t        exp_q [$];
    int          end_q [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hold = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] fr_d [TAUMAX];

    yin_cmnd_search #(
        .WIDTH      (WIDTH),
        .TAUMAX     (TAUMAX),
        .LANES      (LANES),
        .FRAC       (FRAC),
        .DIV_STAGES (DIV_STAGES)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .diff_in          (diff_in),
        .diff_valid_in    (diff_valid),
        .diff_last_in     (diff_last),
        .diff_ready_out   (diff_ready),
        .threshold_in     (threshold),
        .tau_lo_in        (tau_lo),
        .result_valid_out (result_valid),
        .result_ready_in  (result_ready),
        .tau_out          (tau_o),
        .cmnd_out         (cmnd_o),
        .voiced_out       (voiced_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input int t, input int c, input int v);
        exp_t r;
        r.tau = t;
        r.cmnd = c;
        r.voiced = v;
        return r;
    endfunction

    // Reference: cmnd(tau) = tau*d(tau)*2^FRAC / sum_{1..tau} d, then the threshold dip search.
    function automatic exp_t model(input int ntau, input int thr, input int tlo);
        exp_t   r;
        longint sum = 0;
        longint c;
        int     tmin;
        bit     dip = 0;
        bit     lock = 0;
        r = mk(0, int'(CMND_MAX), 0);
        tmin = (tlo < 1) ? 1 : tlo;
        for (int t = 1; t < ntau; t++) begin
            sum += longint'(fr_d[t]);
            if (t < tmin || sum == 0 || lock) continue;
            c = (longint'(t) * longint'(fr_d[t]) * (64'd1 << FRAC)) / sum;
            if (c > CMND_MAX) c = CMND_MAX;
            if (!dip) begin
                if (c < thr) begin
                    dip = 1;
                    r.tau = t;
                    r.cmnd = int'(c);
                end else if (c < r.cmnd) begin
                    r.tau = t;
                    r.cmnd = int'(c);
                end
            end else if (c <= r.cmnd) begin
                r.tau = t;
                r.cmnd = int'(c);
            end else begin
                lock = 1;
            end
        end
        r.voiced = dip;
        return r;
    endfunction

    // Consumer ready: forced low while hold counts down, otherwise optionally random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                result_ready = 1'b0;
                hold--;
            end else begin
                result_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: latency on each new result, stability while stalled, model compare on handshake.
    initial begin
        bit    was_valid = 0;
        bit    held = 0;
        int    h_tau, h_cmnd, h_voiced;
        int    e_end;
        exp_t  e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                was_valid = 0;
                held = 0;
            end else if (result_valid) begin
                if (!was_valid) begin
                    e_end = (end_q.size() > 0) ? end_q.pop_front() : -1000;
                    check("result_latency", cyc - e_end, P);
                end else if (held) begin
                    check("stall_tau_stable", tau_o, h_tau);
                    check("stall_cmnd_stable", cmnd_o, h_cmnd);
                    check("stall_voiced_stable", voiced_o, h_voiced);
                end
                if (result_ready) begin
                    check("scoreboard_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("tau_out", tau_o, e.tau);
                        check("cmnd_out", cmnd_o, e.cmnd);
                        check("voiced_out", voiced_o, e.voiced);
                    end
                    was_valid = 0;
                    held = 0;
                end else begin
                    was_valid = 1;
                    held = 1;
                    h_tau = tau_o;
                    h_cmnd = cmnd_o;
                    h_voiced = voiced_o;
                end
            end else begin
                was_valid = 0;
                held = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        end_q.delete();
        #1;
        check("rst_result_valid", result_valid, 0);
        check("rst_tau_out", tau_o, 0);
        check("rst_cmnd_out", cmnd_o, 0);
        check("rst_voiced_out", voiced_o, 0);
        check("rst_diff_ready", diff_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Streams nb beats of fr_d; called and returns at posedge+1.
    task automatic send_frame(input int nb, input bit use_last, input int thr, input int tlo,
                              input int abort_beat, input bit fixed, input exp_t fx);
        bit rdy;
        int waited;
        if (abort_beat < 0) exp_q.push_back(fixed ? fx : model(nb * LANES, thr, tlo));
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, 2)) begin
                diff_valid = 1'b0;
                diff_in = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk);
                #1;
            end
            for (int j = 0; j < LANES; j++) diff_in[j*DW +: DW] = fr_d[b*LANES + j];
            diff_valid = 1'b1;
            diff_last  = use_last && (b == nb - 1);
            threshold  = (b == 0) ? FRAC'(thr) : FRAC'($urandom);
            tau_lo     = (b == 0) ? TAU_W'(tlo) : TAU_W'($urandom);
            rdy = 0;
            waited = 0;
            while (!rdy && waited < 300) begin
                @(negedge clk);
                rdy = diff_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            check("beat_accepted", rdy, 1);
            if (!rdy) break;
            if (b == nb - 1 && abort_beat < 0) end_q.push_back(cyc);
            if (b == abort_beat) begin
                diff_valid = 1'b0;
                diff_last = 1'b0;
                do_reset();
                return;
            end
        end
        diff_valid = 1'b0;
        diff_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() > 0 && w < 3000) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic fill_case2();
        for (int t = 0; t < TAUMAX; t++) fr_d[t] = 32'd1000;
        fr_d[8] = 32'd10;
    endtask

    task automatic fill_random();
        int mode = $urandom_range(0, 3);
        for (int t = 0; t < TAUMAX; t++) begin
            case (mode)
                0:       fr_d[t] = $urandom_range(500, 1500);
                1:       fr_d[t] = $urandom;
                2:       fr_d[t] = $urandom_range(0, 3);
                default: fr_d[t] = $urandom_range(800, 1200);
            endcase
        end
        if ($urandom_range(0, 1) == 1) fr_d[$urandom_range(1, TAUMAX - 1)] = $urandom_range(0, 80);
    endtask

    initial begin
        exp_t none;
        none = mk(0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("reset_result_valid", result_valid, 0);
        check("reset_tau_out", tau_o, 0);
        check("reset_cmnd_out", cmnd_o, 0);
        check("reset_voiced_out", voiced_o, 0);
        check("reset_diff_ready", diff_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Flat d: every cmnd is exactly 1.0, first occurrence wins.
        for (int t = 0; t < TAUMAX; t++) fr_d[t] = 32'd100;
        fr_d[0] = 32'd0;
        send_frame(4, 1'b0, 102, 0, -1, 1'b1, mk(1, 1024, 0));

        // Dip at tau 8 below threshold, locked by the rise at tau 9.
        fill_case2();
        send_frame(4, 1'b1, 102, 0, -1, 1'b1, mk(8, 11, 1));

        // All-zero frame: no candidate.
        for (int t = 0; t < TAUMAX; t++) fr_d[t] = 32'd0;
        send_frame(4, 1'b1, 102, 0, -1, 1'b1, mk(0, int'(CMND_MAX), 0));
        wait_drain();
        check("no_x_outputs", $isunknown({tau_o, cmnd_o, voiced_o, result_valid}), 0);

        // tau_lo above the dip, then an early diff_last on beat 1.
        fill_case2();
        send_frame(4, 1'b1, 102, 10, -1, 1'b1, mk(15, 1096, 0));
        send_frame(2, 1'b1, 102, 0, -1, 1'b0, none);
        wait_drain();

        // Consumer stalls about 20 cycles on the first result while the next frame waits.
        fill_case2();
        send_frame(4, 1'b1, 102, 0, -1, 1'b1, mk(8, 11, 1));
        hold = P + 20;
        send_frame(4, 1'b1, 102, 0, -1, 1'b1, mk(8, 11, 1));
        wait_drain();

        // Reset after beat 2 of a frame, then a clean frame.
        fill_case2();
        send_frame(4, 1'b1, 102, 0, 2, 1'b0, none);
        send_frame(4, 1'b1, 102, 0, -1, 1'b1, mk(8, 11, 1));
        wait_drain();

        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int nb;
            fill_random();
            nb = $urandom_range(1, 4);
            send_frame(nb, (nb < 4) ? 1'b1 : 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 102 : int'($urandom_range(0, 1023)),
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TAUMAX - 1)) : 0,
                       -1, 1'b0, none);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
